mac_ctrl: RTL and testbench
===========================

MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning array rows and inst_w pipeline depth.
REQ-002 SHALL have parameter col, default 8, meaning array columns and kernel vectors per load.
REQ-003 SHALL have parameter aw, default 11, meaning memory address width.
REQ-004 SHALL have parameter lw, default 8, meaning activation-count width.
REQ-005 SHALL have port clk  input  1  meaning single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  meaning one-cycle job request.
REQ-008 SHALL have port w_base  input  aw  meaning kernel base address.
REQ-009 SHALL have port a_base  input  aw  meaning activation base address.
REQ-010 SHALL have port len  input  lw  meaning activation vector count.
REQ-011 SHALL have port valid  input  col  meaning array output-valid flags, with bit 0 = column 0.
REQ-012 SHALL have port inst_w  output  2  meaning array instruction: 01 = kernel load, 10 = execute, 00 = idle.
REQ-013 SHALL have port cascade  output  1  meaning array row-cascade enable.
REQ-014 SHALL have port mem_cen  output  1  meaning memory chip enable, active-low.
REQ-015 SHALL have port mem_a  output  aw  meaning memory read address.
REQ-016 SHALL have port busy  output  1  meaning high in every state except IDLE.
REQ-017 SHALL have port done  output  1  meaning one-cycle job-complete pulse.

Function
REQ-018 SHALL implement the states IDLE, KLOAD, KGAP, EXEC, DRAIN and DONE.
REQ-019 SHALL, in IDLE with start=1, latch w_base, a_base and len, clear all counters and go to KLOAD; start outside IDLE SHALL be ignored.
REQ-020 SHALL hold KLOAD for exactly col cycles, driving mem_cen=0 and mem_a=w_base+k for k=0..col-1.
REQ-021 SHALL register inst_w one cycle after the matching address, because memory read latency is 1: inst_w=01 for the col cycles following the first KLOAD cycle.
REQ-022 SHALL hold KGAP for row+col cycles with mem_cen=1, so the loaded kernel propagates through the cascade.
REQ-023 SHALL hold EXEC for exactly len cycles, driving mem_cen=0 and mem_a=a_base+n for n=0..len-1, with inst_w=10 delayed one cycle as in REQ-021.
REQ-024 SHALL hold cascade=1 throughout KLOAD, KGAP, EXEC and DRAIN, and cascade=0 in IDLE and DONE.
REQ-025 SHALL count cycles with valid[0]=1 in a counter of width lw+1, counting only in EXEC and DRAIN.
REQ-026 SHALL leave DRAIN for DONE in the cycle after the count equals len.
REQ-027 SHALL skip EXEC and DRAIN when len=0, going KGAP->DONE.
REQ-028 SHALL raise done for exactly one cycle in DONE, then return to IDLE; a start in that cycle SHALL be ignored.
REQ-029 SHALL wrap mem_a modulo 2^aw when base plus offset overflows.
REQ-030 SHALL drive inst_w=00, mem_cen=1, mem_a=0 and done=0 outside the active windows.
REQ-031 SHALL make the job atomic: no abort input; only reset terminates a job.

Reset
REQ-032 SHALL, on reset=0 (any state, asynchronously), force state=IDLE, inst_w=00, cascade=0, mem_cen=1, mem_a=0, busy=0, done=0 and all counters and latches to 0.
REQ-033 SHALL ignore start on the first clock edge after reset deasserts if that edge coincides with the deassertion; start is sampled from the next edge.

Verification
REQ-034 SHALL cover: start with w_base=0x010, a_base=0x100, len=4 -> mem_a 0x010..0x017 with mem_cen=0 for 8 cycles, then 16 gap cycles, then 0x100..0x103, with inst_w lagging one cycle each.
REQ-035 SHALL cover: same job with four valid[0] pulses injected during DRAIN -> done pulses exactly one cycle after the 4th pulse, then busy=0.
REQ-036 SHALL cover: len=0 -> no EXEC addresses, and done exactly 8+16 cycles after KLOAD entry.
REQ-037 SHALL cover: start pulsed while busy -> no effect on addresses or counts.
REQ-038 SHALL cover: reset=0 asserted mid-EXEC -> outputs at reset values immediately, before the next clock edge, and a new job runs correctly afterwards.
REQ-039 SHALL cover: a_base=0x7FE, len=4 -> mem_a sequence 0x7FE, 0x7FF, 0x000, 0x001.

Source files
------------

// File: rtl/mac_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_ctrl_if
//  Purpose  : Job-request, array-control and memory-read signals of the
//             MAC array controller, bundled with host and controller views.
//  Revision : 1.0  initial release
// ============================================================================
interface mac_ctrl_if #(
    parameter int col = 8,
    parameter int aw  = 11,
    parameter int lw  = 8
);
    logic           start;
    logic [aw-1:0]  w_base;
    logic [aw-1:0]  a_base;
    logic [lw-1:0]  len;
    logic [col-1:0] valid;
    logic [1:0]     inst_w;
    logic           cascade;
    logic           mem_cen;
    logic [aw-1:0]  mem_a;
    logic           busy;
    logic           done;

    // Host / array side: issues jobs and reports column valid flags.
    modport master (
        output start, w_base, a_base, len, valid,
        input  inst_w, cascade, mem_cen, mem_a, busy, done
    );

    // Controller side.
    modport slave (
        input  start, w_base, a_base, len, valid,
        output inst_w, cascade, mem_cen, mem_a, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mac_ctrl
//  Purpose  : Sequences one MAC-array job: kernel load from memory, cascade
//             propagation gap, activation streaming, then drains until the
//             array has reported one valid result per activation vector.
//  Revision : 1.0  initial release
// ============================================================================
module mac_ctrl #(
    parameter int row = 8,
    parameter int col = 8,
    parameter int aw  = 11,
    parameter int lw  = 8
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mac_ctrl_if.slave  bus
);

    // Phase counter must hold the kernel index, the gap length and the
    // activation index, whichever is widest.
    localparam int c_gap_w = (row + col > 2) ? $clog2(row + col) : 1;
    localparam int c_cw    = (c_gap_w > lw) ? c_gap_w : lw;

    localparam logic [c_cw-1:0] c_one        = c_cw'(1);
    localparam logic [c_cw-1:0] c_kload_last = c_cw'(col - 1);
    localparam logic [c_cw-1:0] c_kgap_last  = c_cw'(row + col - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KLOAD = 3'd1,
        S_KGAP  = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_armed;
    logic [aw-1:0]   r_w_base;
    logic [aw-1:0]   r_a_base;
    logic [lw-1:0]   r_len;
    logic [c_cw-1:0] r_idx;
    logic [lw:0]     r_cnt;

    logic [1:0]      r_inst_w;
    logic            r_cascade;
    logic            r_mem_cen;
    logic [aw-1:0]   r_mem_a;
    logic            r_busy;
    logic            r_done;

    logic [c_cw-1:0] w_idx_inc;
    logic            w_exec_last;
    logic            w_cnt_en;
    logic [lw:0]     w_cnt_next;
    logic            w_drain_done;
    logic            w_unused_valid;

    assign w_idx_inc    = r_idx + c_one;
    assign w_exec_last  = (w_idx_inc == c_cw'(r_len));
    // Only column 0 paces the drain; the other columns finish in lockstep.
    assign w_cnt_en     = ((r_state == S_EXEC) || (r_state == S_DRAIN)) && bus.valid[0];
    assign w_cnt_next   = r_cnt + (lw + 1)'(w_cnt_en);
    // >= rather than == so results that all arrived during EXEC still end the job.
    assign w_drain_done = (w_cnt_next >= {1'b0, r_len});
    assign w_unused_valid = |bus.valid;

    assign bus.inst_w  = r_inst_w;
    assign bus.cascade = r_cascade;
    assign bus.mem_cen = r_mem_cen;
    assign bus.mem_a   = r_mem_a;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Job sequencer: state, counters, latched job parameters and all outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_w_base  <= '0;
            r_a_base  <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_inst_w  <= 2'b00;
            r_cascade <= 1'b0;
            r_mem_cen <= 1'b1;
            r_mem_a   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // The edge that releases reset never accepts a job; from the
            // following edge onward start is honoured.
            r_armed <= 1'b1;
            r_done  <= 1'b0;
            r_cnt   <= w_cnt_next;

            // Memory read latency is one cycle, so the instruction follows
            // the address phase of the state just completed.
            case (r_state)
                S_KLOAD: r_inst_w <= 2'b01;
                S_EXEC:  r_inst_w <= 2'b10;
                default: r_inst_w <= 2'b00;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (bus.start && r_armed) begin
                        r_w_base  <= bus.w_base;
                        r_a_base  <= bus.a_base;
                        r_len     <= bus.len;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        r_state   <= S_KLOAD;
                        r_cascade <= 1'b1;
                        r_busy    <= 1'b1;
                        r_mem_cen <= 1'b0;
                        r_mem_a   <= bus.w_base;
                    end
                end

                S_KLOAD: begin
                    if (r_idx == c_kload_last) begin
                        r_idx     <= '0;
                        r_state   <= S_KGAP;
                        r_mem_cen <= 1'b1;
                        r_mem_a   <= '0;
                    end else begin
                        r_idx   <= w_idx_inc;
                        r_mem_a <= r_w_base + aw'(w_idx_inc);
                    end
                end

                S_KGAP: begin
                    if (r_idx == c_kgap_last) begin
                        r_idx <= '0;
                        if (r_len == '0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cascade <= 1'b0;
                        end else begin
                            r_state   <= S_EXEC;
                            r_mem_cen <= 1'b0;
                            r_mem_a   <= r_a_base;
                        end
                    end else begin
                        r_idx <= w_idx_inc;
                    end
                end

                S_EXEC: begin
                    if (w_exec_last) begin
                        r_idx     <= '0;
                        r_state   <= S_DRAIN;
                        r_mem_cen <= 1'b1;
                        r_mem_a   <= '0;
                    end else begin
                        r_idx   <= w_idx_inc;
                        r_mem_a <= r_a_base + aw'(w_idx_inc);
                    end
                end

                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cascade <= 1'b0;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cascade <= 1'b0;
                    r_mem_cen <= 1'b1;
                    r_mem_a   <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_ctrl
//  Purpose  : Directed, table-driven checks of the MAC array controller:
//             per-cycle output timeline for several jobs plus reset cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_ctrl;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int LW  = 8;
    localparam int E0  = 2 * COL + ROW + 1;   // first EXEC cycle after start edge

    typedef struct packed {
        logic [1:0]    inst_w;
        logic          cascade;
        logic          mem_cen;
        logic [AW-1:0] mem_a;
        logic          busy;
        logic          done;
    } outs_t;

    typedef struct {
        logic [AW-1:0] w_base;
        logic [AW-1:0] a_base;
        logic [LW-1:0] len;
        bit            noise;     // pulse start / change inputs while busy
        bit            wrap;      // explicit activation wrap sequence check
        int            exp_done;  // hand-computed cycle of the done pulse
    } job_t;

    logic clk;
    logic reset;

    mac_ctrl_if #(.col(COL), .aw(AW), .lw(LW)) bus ();

    mac_ctrl #(.row(ROW), .col(COL), .aw(AW), .lw(LW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks;
    int    n_errors;
    job_t  jobs [5];
    outs_t rst_vals;
    logic [AW-1:0] wrap_seq [4];

    function automatic outs_t cur_out();
        outs_t o;
        o.inst_w  = bus.inst_w;
        o.cascade = bus.cascade;
        o.mem_cen = bus.mem_cen;
        o.mem_a   = bus.mem_a;
        o.busy    = bus.busy;
        o.done    = bus.done;
        return o;
    endfunction

    task automatic check_out(input string name, input outs_t exp);
        outs_t got;
        got = cur_out();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got inst_w=%b cas=%b cen=%b a=%h busy=%b done=%b, want inst_w=%b cas=%b cen=%b a=%h busy=%b done=%b",
                     name, got.inst_w, got.cascade, got.mem_cen, got.mem_a, got.busy, got.done,
                     exp.inst_w, exp.cascade, exp.mem_cen, exp.mem_a, exp.busy, exp.done);
        end
    endtask

    // Expected outputs in cycle t (t=1 is the first cycle after the start edge).
    function automatic outs_t exp_out(input int j, input int t);
        outs_t o;
        int    d;
        int    n;
        d = jobs[j].exp_done;
        n = int'(jobs[j].len);
        o = rst_vals;
        if (t < d) begin
            o.cascade = 1'b1;
            o.busy    = 1'b1;
        end
        if (t == d) begin
            o.busy = 1'b1;
            o.done = 1'b1;
        end
        if (t >= 1 && t <= COL) begin
            o.mem_cen = 1'b0;
            o.mem_a   = jobs[j].w_base + AW'(t - 1);
        end
        if (t >= 2 && t <= COL + 1) o.inst_w = 2'b01;
        if (n > 0 && t >= E0 && t < E0 + n) begin
            o.mem_cen = 1'b0;
            o.mem_a   = jobs[j].a_base + AW'(t - E0);
        end
        if (n > 0 && t > E0 && t <= E0 + n) o.inst_w = 2'b10;
        return o;
    endfunction

    // valid[0] pulses on len consecutive cycles starting one cycle into DRAIN;
    // the upper columns are held high throughout to show they are ignored.
    function automatic logic [COL-1:0] drive_valid(input int j, input int t);
        logic [COL-1:0] v;
        int n;
        n = int'(jobs[j].len);
        v = '1;
        v[0] = (n > 0) && (t >= E0 + n + 1) && (t <= E0 + 2 * n);
        return v;
    endfunction

    task automatic run_job(input int j);
        int d;
        d = jobs[j].exp_done;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.w_base = jobs[j].w_base;
        bus.a_base = jobs[j].a_base;
        bus.len    = jobs[j].len;
        for (int t = 1; t <= d + 2; t++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (jobs[j].noise && (t == 3 || t == 12 || t == 26 || t == d)) bus.start = 1'b1;
            if (jobs[j].noise && t == 3) begin
                bus.w_base = 11'h555;
                bus.a_base = 11'h2AA;
                bus.len    = 8'd9;
            end
            bus.valid = (t <= d) ? drive_valid(j, t) : '0;
            @(negedge clk);
            check_out($sformatf("job%0d_cyc%0d", j, t), exp_out(j, t));
            if (jobs[j].wrap && t >= E0 && t < E0 + 4) begin
                n_checks++;
                if (bus.mem_a !== wrap_seq[t - E0]) begin
                    n_errors++;
                    $display("FAIL wrap_addr%0d: got %h want %h", t - E0, bus.mem_a, wrap_seq[t - E0]);
                end
            end
        end
        bus.start = 1'b0;
        bus.valid = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_vals = '{inst_w: 2'b00, cascade: 1'b0, mem_cen: 1'b1, mem_a: '0, busy: 1'b0, done: 1'b0};
        wrap_seq[0] = 11'h7FE;
        wrap_seq[1] = 11'h7FF;
        wrap_seq[2] = 11'h000;
        wrap_seq[3] = 11'h001;
        //               w_base   a_base   len  noise wrap done
        jobs[0] = '{11'h010, 11'h100, 8'd4, 1'b0, 1'b0, 34};
        jobs[1] = '{11'h010, 11'h100, 8'd0, 1'b0, 1'b0, 25};
        jobs[2] = '{11'h7FC, 11'h7FE, 8'd4, 1'b0, 1'b1, 34};
        jobs[3] = '{11'h020, 11'h200, 8'd3, 1'b1, 1'b0, 32};
        jobs[4] = '{11'h000, 11'h7FF, 8'd1, 1'b0, 1'b0, 28};

        // Reset held with start high: outputs at reset values.
        reset      = 1'b0;
        bus.start  = 1'b1;
        bus.w_base = 11'h010;
        bus.a_base = 11'h100;
        bus.len    = 8'd4;
        bus.valid  = '0;
        repeat (2) @(posedge clk);
        #2;
        check_out("in_reset", rst_vals);

        // Release reset on a clock edge while start is high: must be ignored.
        @(posedge clk);
        reset = 1'b1;
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_out("start_at_release", rst_vals);

        for (int j = 0; j < 5; j++) run_job(j);

        // Asynchronous reset in the middle of EXEC.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.w_base = jobs[0].w_base;
        bus.a_base = jobs[0].a_base;
        bus.len    = jobs[0].len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (25) @(posedge clk);
        #3;
        check_out("mid_exec", '{inst_w: 2'b10, cascade: 1'b1, mem_cen: 1'b0, mem_a: 11'h101, busy: 1'b1, done: 1'b0});
        reset = 1'b0;
        #1;
        check_out("async_reset", rst_vals);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_out("after_reset", rst_vals);

        run_job(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
